// File: rtl/fir_coeff_loader_if.sv
// Coefficient stream channel for fir_coeff_loader: one word per valid/ready transfer.
// The producer drives the master modport; the loader uses the slave modport.
interface fir_coeff_loader_if #(
    parameter int DATA_WIDTH = 24
);
    logic [DATA_WIDTH-1:0] iv_coeff;
    logic                  i_coeff_valid;
    logic                  o_coeff_ready;

    modport master (
        output iv_coeff,
        output i_coeff_valid,
        input  o_coeff_ready
    );

    modport slave (
        input  iv_coeff,
        input  i_coeff_valid,
        output o_coeff_ready
    );
endinterface

// File: rtl/fir_coeff_loader.sv
// Double-buffered run-time coefficient bank for the transposed-form FIR chain.
// Define FIR_COEFF_CHECKSUM_EN to require a trailing modulo-2^DATA_WIDTH checksum word.
module fir_coeff_loader #(
    parameter int DATA_WIDTH = 24,
    parameter int FIR_DEPTH  = 128
) (
    input  logic                            i_clk,
    input  logic                            i_rst,
    input  logic                            i_en,
    input  logic                            i_start,
    fir_coeff_loader_if.slave               coeff_bus,
    output logic [FIR_DEPTH*DATA_WIDTH-1:0] ov_weights,
    output logic                            o_busy,
    output logic                            o_loaded,
    output logic                            o_err
);

    localparam int                IDX_W    = (FIR_DEPTH > 1) ? $clog2(FIR_DEPTH) : 1;
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(FIR_DEPTH - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
`ifdef FIR_COEFF_CHECKSUM_EN
    localparam logic [1:0] ST_CHECK = 2'd2;
`endif
    localparam logic [1:0] ST_PEND  = 2'd3;

    logic [1:0]            r_state;
    logic [IDX_W-1:0]      r_idx;
    logic [DATA_WIDTH-1:0] r_shadow [FIR_DEPTH];
    logic [DATA_WIDTH-1:0] r_active [FIR_DEPTH];
    logic                  r_loaded;
    logic                  r_err;

    logic [1:0]            w_state_nxt;
    logic [IDX_W-1:0]      w_idx_nxt;
    logic                  w_ready;
    logic                  w_xfer;
    logic                  w_shadow_we;
    logic                  w_swap;
    logic                  w_restart;
    logic                  w_reject;

`ifdef FIR_COEFF_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] r_csum;
    logic                  w_csum_clr;

    assign w_ready    = (r_state == ST_LOAD) || (r_state == ST_CHECK);
    assign w_csum_clr = ((r_state == ST_IDLE) && i_start) || w_restart;
`else
    assign w_ready    = (r_state == ST_LOAD);
`endif

    assign w_xfer                  = coeff_bus.i_coeff_valid & w_ready;
    assign coeff_bus.o_coeff_ready = w_ready;

    // Next-state decode. A restart request wins over a same-cycle transfer,
    // so the word presented alongside i_start never reaches the shadow bank.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // through the case statement can leave a value held and infer a latch.
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_shadow_we = 1'b0;
        w_swap      = 1'b0;
        w_restart   = 1'b0;
        w_reject    = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_state_nxt = ST_LOAD;
                    w_idx_nxt   = '0;
                end
            end

            ST_LOAD: begin
                if (i_start) begin
                    w_idx_nxt = '0;
                    w_restart = 1'b1;
                end else if (w_xfer) begin
                    w_shadow_we = 1'b1;
                    if (r_idx == LAST_IDX) begin
                        w_idx_nxt = '0;
`ifdef FIR_COEFF_CHECKSUM_EN
                        w_state_nxt = ST_CHECK;
`else
                        w_state_nxt = ST_PEND;
`endif
                    end else begin
                        w_idx_nxt = r_idx + 1'b1;
                    end
                end
            end

`ifdef FIR_COEFF_CHECKSUM_EN
            ST_CHECK: begin
                if (i_start) begin
                    w_state_nxt = ST_LOAD;
                    w_idx_nxt   = '0;
                    w_restart   = 1'b1;
                end else if (w_xfer) begin
                    if (coeff_bus.iv_coeff == r_csum) begin
                        w_state_nxt = ST_PEND;
                    end else begin
                        w_state_nxt = ST_IDLE;
                        w_reject    = 1'b1;
                    end
                end
            end
`endif

            ST_PEND: begin
                // The swap is tied to the filter strobe so the tap chain sees
                // one complete set per sample.
                if (i_en) begin
                    w_swap      = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
                w_idx_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (i_rst) begin
            r_state  <= ST_IDLE;
            r_idx    <= '0;
            r_loaded <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_idx    <= w_idx_nxt;
            r_loaded <= w_swap;
            r_err    <= w_restart | w_reject;
        end
    end

    // NOTE: both banks are cleared on reset because a freshly reset filter must
    // run with all-zero weights; this costs a reset net on every bank flop.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int k = 0; k < FIR_DEPTH; k++) begin
                r_shadow[k] <= '0;
            end
        end else if (w_shadow_we) begin
            r_shadow[r_idx] <= coeff_bus.iv_coeff;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int k = 0; k < FIR_DEPTH; k++) begin
                r_active[k] <= '0;
            end
        end else if (w_swap) begin
            r_active <= r_shadow;
        end
    end

`ifdef FIR_COEFF_CHECKSUM_EN
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_csum <= '0;
        end else if (w_csum_clr) begin
            r_csum <= '0;
        end else if (w_shadow_we) begin
            r_csum <= r_csum + coeff_bus.iv_coeff;
        end
    end
`endif

    for (genvar k = 0; k < FIR_DEPTH; k++) begin : g_flatten
        assign ov_weights[k*DATA_WIDTH +: DATA_WIDTH] = r_active[k];
    end

    assign o_busy   = (r_state != ST_IDLE);
    assign o_loaded = r_loaded;
    assign o_err    = r_err;

    a_ready_implies_busy: assert property (
        @(posedge i_clk) disable iff (i_rst) coeff_bus.o_coeff_ready |-> o_busy);

    a_idx_in_range: assert property (
        @(posedge i_clk) disable iff (i_rst) r_idx <= LAST_IDX);

    a_loaded_err_exclusive: assert property (
        @(posedge i_clk) disable iff (i_rst) !(o_loaded && o_err));

endmodule

// File: tb/tb_fir_coeff_loader.sv
// Directed self-checking bench for fir_coeff_loader at FIR_DEPTH=4, DATA_WIDTH=8.
// Checksum vectors are exercised when FIR_COEFF_CHECKSUM_EN is defined.
module tb_fir_coeff_loader;

    localparam int DW    = 8;
    localparam int DEPTH = 4;

    logic clk   = 1'b0;
    logic rst   = 1'b1;
    logic en    = 1'b0;
    logic start = 1'b0;

    logic [DEPTH*DW-1:0] weights;
    logic                busy;
    logic                loaded;
    logic                err;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    fir_coeff_loader_if #(.DATA_WIDTH(DW)) bus ();

    fir_coeff_loader #(
        .DATA_WIDTH (DW),
        .FIR_DEPTH  (DEPTH)
    ) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_en       (en),
        .i_start    (start),
        .coeff_bus  (bus),
        .ov_weights (weights),
        .o_busy     (busy),
        .o_loaded   (loaded),
        .o_err      (err)
    );

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Outputs are observed 1 ns after the rising edge; inputs change there too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_load();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send(input logic [DW-1:0] w, input logic e);
        bus.iv_coeff      = w;
        bus.i_coeff_valid = 1'b1;
        en                = e;
        tick();
        bus.i_coeff_valid = 1'b0;
        en                = 1'b0;
    endtask

    task automatic send_sum(input logic [DW-1:0] s, input logic e);
`ifdef FIR_COEFF_CHECKSUM_EN
        send(s, e);
`else
        if (e) begin
            en = 1'b1;
            tick();
            en = 1'b0;
        end
        bus.iv_coeff = s;
`endif
    endtask

    task automatic pulse_en();
        en = 1'b1;
        tick();
        en = 1'b0;
    endtask

    initial begin
        bus.iv_coeff      = '0;
        bus.i_coeff_valid = 1'b0;

        // Reset state
        tick();
        check("rst_weights", weights, 0);
        check("rst_busy",    busy,    0);
        check("rst_ready",   bus.o_coeff_ready, 0);
        check("rst_loaded",  loaded,  0);
        check("rst_err",     err,     0);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("idle_weights", weights, 0);
            check("idle_busy",    busy,    0);
            check("idle_ready",   bus.o_coeff_ready, 0);
        end

        // Words offered in IDLE are ignored
        send(8'h55, 1'b0);
        send(8'h66, 1'b0);
        check("idle_word_busy", busy, 0);

        // Basic load, swap deferred until i_en
        start_load();
        check("t2_ready", bus.o_coeff_ready, 1);
        check("t2_busy",  busy, 1);
        send(8'h01, 1'b0);
        send(8'h02, 1'b0);
        send(8'hFF, 1'b0);
        send(8'h7F, 1'b0);
        send_sum(8'h81, 1'b0);
        check("t2_pend_ready", bus.o_coeff_ready, 0);
        check("t2_pend_busy",  busy, 1);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t2_hold_weights", weights, 0);
            check("t2_hold_loaded",  loaded,  0);
        end
        en = 1'b1;
        check("t2_pre_edge", weights, 0);
        tick();
        en = 1'b0;
        check("t2_weights", weights, 32'h7FFF0201);
        check("t2_loaded",  loaded, 1);
        check("t2_idle",    busy,   0);
        tick();
        check("t2_loaded_once", loaded, 0);
        check("t2_stable",      weights, 32'h7FFF0201);

        // Valid toggling, i_start ignored in PENDING
        start_load();
        send(8'h11, 1'b0); bus.iv_coeff = 8'hEE; tick();
        send(8'h22, 1'b0); bus.iv_coeff = 8'hEE; tick();
        send(8'h33, 1'b0); bus.iv_coeff = 8'hEE; tick();
        send(8'h44, 1'b0); bus.iv_coeff = 8'hEE; tick();
        send_sum(8'hAA, 1'b0);
        check("t3_no_swap", weights, 32'h7FFF0201);
        check("t3_ready",   bus.o_coeff_ready, 0);
        start_load();
        check("t3_pend_start_busy", busy, 1);
        check("t3_pend_start_err",  err,  0);
        check("t3_pend_start_rdy",  bus.o_coeff_ready, 0);
        pulse_en();
        check("t3_weights", weights, 32'h44332211);
        check("t3_loaded",  loaded, 1);

        // Restart mid-load discards words, including the one beside i_start
        start_load();
        send(8'hAA, 1'b0);
        send(8'hBB, 1'b0);
        start             = 1'b1;
        bus.iv_coeff      = 8'hCC;
        bus.i_coeff_valid = 1'b1;
        tick();
        start             = 1'b0;
        bus.i_coeff_valid = 1'b0;
        check("t4_err",   err, 1);
        check("t4_ready", bus.o_coeff_ready, 1);
        send(8'h10, 1'b0);
        check("t4_err_once", err, 0);
        send(8'h20, 1'b0);
        send(8'h30, 1'b0);
        send(8'h40, 1'b0);
        send_sum(8'hA0, 1'b0);
        pulse_en();
        check("t4_weights", weights, 32'h40302010);

        // Last transfer coincides with i_en: no swap that cycle
        start_load();
        send(8'h05, 1'b0);
        send(8'h06, 1'b0);
        send(8'h07, 1'b0);
`ifdef FIR_COEFF_CHECKSUM_EN
        send(8'h08, 1'b0);
        send(8'h1A, 1'b1);
`else
        send(8'h08, 1'b1);
`endif
        check("t5_no_swap",  weights, 32'h40302010);
        check("t5_busy",     busy,   1);
        check("t5_loaded",   loaded, 0);
        tick();
        check("t5_still",    weights, 32'h40302010);
        pulse_en();
        check("t5_weights",  weights, 32'h08070605);
        check("t5_loaded2",  loaded, 1);

`ifdef FIR_COEFF_CHECKSUM_EN
        // Checksum accepted
        start_load();
        send(8'h01, 1'b0);
        send(8'h02, 1'b0);
        send(8'h03, 1'b0);
        send(8'h04, 1'b0);
        check("cs_check_ready", bus.o_coeff_ready, 1);
        check("cs_check_busy",  busy, 1);
        send(8'h0A, 1'b0);
        check("cs_pend_ready", bus.o_coeff_ready, 0);
        check("cs_ok_err",     err, 0);
        pulse_en();
        check("cs_ok_weights", weights, 32'h04030201);

        // Checksum rejected
        start_load();
        send(8'h01, 1'b0);
        send(8'h02, 1'b0);
        send(8'h03, 1'b0);
        send(8'h04, 1'b0);
        send(8'h0B, 1'b0);
        check("cs_bad_err",     err,  1);
        check("cs_bad_busy",    busy, 0);
        check("cs_bad_weights", weights, 32'h04030201);
        tick();
        check("cs_bad_err_once", err, 0);
        pulse_en();
        check("cs_bad_no_swap", weights, 32'h04030201);
        check("cs_bad_loaded",  loaded, 0);
`endif

        // Reset mid-load clears everything, then a fresh load still works
        start_load();
        send(8'h99, 1'b0);
        send(8'h98, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_weights", weights, 0);
        check("mid_rst_busy",    busy,    0);
        check("mid_rst_ready",   bus.o_coeff_ready, 0);
        start_load();
        send(8'h01, 1'b0);
        send(8'h01, 1'b0);
        send(8'h01, 1'b0);
        send(8'h01, 1'b0);
        send_sum(8'h04, 1'b0);
        pulse_en();
        check("mid_rst_reload", weights, 32'h01010101);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/fir_coeff_loader.md
Name: fir_coeff_loader

Overview:
Run-time coefficient source for the transposed-form FIR tap chain. It replaces compile-time weights with a double-buffered register bank.
- Coefficients stream in over a valid/ready handshake into a shadow bank.
- The full set is committed atomically to the active bank on a sample-enable boundary, so the filter never runs on a partially loaded set.
- The active bank drives the per-tap weight inputs of the FIR chain.

Parameters:
DATA_WIDTH, 24, coefficient width in bits (signed two's complement; matches the filter sample width)
FIR_DEPTH, 128, number of taps/coefficients; must be >= 2

Ports:
i_clk  input  1  system clock
i_rst  input  1  synchronous active-high reset
i_en  input  1  filter sample strobe (same signal that drives the FIR chain); bank swaps occur only on cycles where this is 1
i_start  input  1  single-cycle request to begin loading a new coefficient set
iv_coeff  input  DATA_WIDTH  coefficient word; first accepted word goes to tap 0, last to tap FIR_DEPTH-1
i_coeff_valid  input  1  iv_coeff is valid
o_coeff_ready  output  1  loader accepts a word this cycle
ov_weights  output  FIR_DEPTH*DATA_WIDTH  active bank, flattened; tap k occupies bits [k*DATA_WIDTH +: DATA_WIDTH]
o_busy  output  1  high in any state other than IDLE
o_loaded  output  1  one-cycle pulse the cycle after the active bank is updated
o_err  output  1  one-cycle pulse on aborted or rejected load

Behaviour:
- Reset, the cycle after i_rst=1:
  - state IDLE; index counter 0; shadow and active banks all zero.
  - ov_weights=0, o_coeff_ready=0, o_busy=0, o_loaded=0, o_err=0.
  - Reset mid-load discards everything; there is no partial commit.
- States: IDLE, LOAD, CHECK (only with the optional feature), PENDING.
- IDLE: i_start=1 -> LOAD next cycle with index=0. Words presented in IDLE are ignored.
- LOAD:
  - o_coeff_ready=1, driven combinationally from state.
  - Transfer = i_coeff_valid & o_coeff_ready. Each transfer writes shadow[index] and increments index.
  - Transfer at index=FIR_DEPTH-1 -> PENDING (or CHECK if the feature is enabled).
  - Valid may deassert at any time; the loader holds its state with no timeout.
- i_start=1 while in LOAD:
  - Restart: index=0, o_err pulses next cycle, state remains LOAD.
  - Any word transferred in that same cycle is discarded.
- PENDING:
  - o_coeff_ready=0; i_start is ignored.
  - On the first cycle with i_en=1: active <= shadow on that clock edge, state -> IDLE, o_loaded=1 the following cycle.
- Boundary: if the last word transfers in a cycle where i_en=1, there is no swap that cycle. The swap waits for the next i_en assertion in PENDING.
- Latency:
  - ov_weights changes on the edge of the first i_en cycle after reaching PENDING.
  - Minimum from final transfer to new ov_weights is 2 clock edges.
- ov_weights is registered and stable between swaps; it never exposes shadow contents.
- The index counter is $clog2(FIR_DEPTH) bits and wraps only through state transitions, never arithmetically.

Optional Feature:
Macro FIR_COEFF_CHECKSUM_EN.
- Defined:
  - After the FIR_DEPTH-th word the loader enters CHECK with o_coeff_ready=1 and accepts exactly one extra word.
  - That word is the expected checksum: the modulo-2^DATA_WIDTH sum of all coefficients. A running accumulator is cleared on entry to LOAD or on restart.
  - Match -> PENDING.
  - Mismatch -> IDLE, o_err pulse, active bank unchanged.
  - i_start in CHECK behaves as in LOAD (restart).
- Not defined: CHECK state and accumulator are absent; the last coefficient goes directly to PENDING.

Test Plan:
- Reset, then hold i_en=0: ov_weights=0, o_busy=0, o_coeff_ready=0 across 10 cycles.
- FIR_DEPTH=4, DATA_WIDTH=8, i_start then words 0x01,0x02,0xFF,0x7F with valid every cycle, then i_en pulse 5 cycles later:
  - ov_weights stays 0 until that i_en edge, then equals 0x7FFF0201.
  - o_loaded pulses once, the next cycle.
- Same load with valid toggling 1,0,1,0: only the 4 accepted words land, in order; no swap before i_en.
- i_start after 2 words, then 4 fresh words 0x10,0x20,0x30,0x40:
  - o_err pulses once.
  - After i_en, ov_weights=0x40302010.
- Last word accepted with i_en=1 in the same cycle: ov_weights unchanged; swap occurs on the next i_en.
- Checksum enabled, words 1,2,3,4:
  - Checksum 0x0A: commit as normal.
  - Checksum 0x0B: o_err pulses, ov_weights keeps its previous value, state returns to IDLE.
